mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit and sequencer for the 5-stage pipeline.
- Accepts mult/div/move-to-HI/LO operations from the E stage and runs them over a fixed multi-cycle latency.
- Owns the HI/LO registers.
- Produces `md_stall`, which the hazard unit ORs into its stall, so that no D-stage MDU instruction advances while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/msub when enabled); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- E_A  input  32  forwarded rs operand of the E-stage instruction
- E_B  input  32  forwarded rt operand of the E-stage instruction
- E_mdop  input  4  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 msub; others treated as none
- D_md_use  input  1  D-stage instruction is any MDU op, including mfhi/mflo
- start  output  1  combinational: E_mdop is a multi-cycle op and state is IDLE
- busy  output  1  registered: a multi-cycle op is in progress
- md_stall  output  1  combinational: D_md_use && (start || busy)
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset (synchronous, active-high): state IDLE, busy=0, counter=0, HI=0, LO=0, staged result cleared.
  - Reset mid-operation cancels the op; HI/LO end at 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE with start=1 (mult/multu/div/divu, or madd/msub when enabled):
  - Compute the result combinationally from E_A/E_B and latch it into staging registers {sHI,sLO}.
  - Load counter with the op's latency: MULT_CYCLES or DIV_CYCLES.
  - Next state RUN.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit; sHI = upper word, sLO = lower word.
  - multu: unsigned 32x32 -> 64-bit; same split.
  - div: signed; sLO = quotient truncated toward zero; sHI = remainder, with the sign of the dividend.
  - divu: unsigned; sLO = quotient, sHI = remainder.
  - Divide by zero: sHI/sLO = current HI/LO, so HI/LO are unchanged; the full DIV_CYCLES latency still applies.
- RUN:
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0: HI/LO <= sHI/sLO, state returns to IDLE, busy falls.
  - busy is high for exactly N consecutive cycles following the start cycle.
  - The first mfhi/mflo able to read the result reads it in the cycle busy is low.
- mthi/mtlo in IDLE: HI (or LO) <= E_A on the next edge; no busy.
- Ops arriving while busy (any E_mdop≠0):
  - Ignored; HI/LO and the in-flight result are unaffected.
  - md_stall guarantees this does not occur in correct pipeline use.
  - The bench flags any occurrence as an error.
- HI/LO outputs are the registers themselves; there is no bypass of the staged result.
- md_stall:
  - Asserted during the start cycle and every busy cycle whenever D_md_use=1.
  - Deasserted in the first cycle after busy falls.
- A multi-cycle op back-to-back with a completion: legal only once IDLE is reached. start cannot assert in the same cycle busy falls, because state is still RUN in that cycle.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - E_mdop 7 (madd) and 8 (msub) are legal multi-cycle ops with latency MULT_CYCLES and signed product.
  - {HI,LO} <= {HI,LO} ± (E_A*E_B), evaluated at completion against the HI/LO values present at that edge, with 64-bit wrap-around.
- Undefined: E_mdop 7 and 8 behave as none (start=0, no state change).

Test Plan:
- mult, E_A=3, E_B=0xFFFFFFFE -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- div, E_A=0xFFFFFFF9 (-7), E_B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, 7/2 -> LO=3, HI=1.
- mthi 0x12345678, then mtlo 0x9 on consecutive idle cycles -> HI=0x12345678, LO=0x9; busy never asserts.
- divu by 0 with HI=0xA, LO=0xB -> busy 10 cycles, HI/LO remain 0xA/0xB.
- multu started, D_md_use=1 held -> md_stall=1 for the start cycle plus 5 busy cycles, 0 afterwards. With D_md_use=0 -> md_stall=0 throughout.
- reset asserted on the 3rd busy cycle of div -> next cycle busy=0, HI=LO=0, no later update. With MDU_MADD_EN: HI=0, LO=1, madd 2*3 -> LO=7.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning HI/LO; results land after a fixed latency.
// Optional madd/msub support is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic [3:0]  E_mdop,
    input  logic        D_md_use,
    output logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] shi_q, shi_d, slo_q, slo_d;

    logic        is_mul, is_div, is_sgn, is_acc;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic [63:0] a_ext, b_ext, prod;

`ifdef MDU_MADD_EN
    logic [1:0]  acc_q, acc_d;
`endif

    always_comb begin
        is_mul = (E_mdop == 4'd1) || (E_mdop == 4'd2);
        is_div = (E_mdop == 4'd3) || (E_mdop == 4'd4);
`ifdef MDU_MADD_EN
        is_acc = (E_mdop == 4'd7) || (E_mdop == 4'd8);
`else
        is_acc = 1'b0;
`endif
        is_sgn = (E_mdop == 4'd1) || (E_mdop == 4'd3) || is_acc;

        // One shared multiplier and one unsigned divider on magnitudes.
        a_ext = is_sgn ? {{32{E_A[31]}}, E_A} : {32'd0, E_A};
        b_ext = is_sgn ? {{32{E_B[31]}}, E_B} : {32'd0, E_B};
        prod  = a_ext * b_ext;

        a_neg = is_sgn & E_A[31];
        b_neg = is_sgn & E_B[31];
        a_mag = a_neg ? 32'd0 - E_A : E_A;
        b_mag = b_neg ? 32'd0 - E_B : E_B;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quo   = (a_neg ^ b_neg) ? 32'd0 - q_mag : q_mag;
        rem   = a_neg ? 32'd0 - r_mag : r_mag;

        start = (state_q == IDLE) && (is_mul || is_div || is_acc);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        shi_d   = shi_q;
        slo_d   = slo_q;
`ifdef MDU_MADD_EN
        acc_d   = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    if (is_div) begin
                        cnt_d = 4'(DIV_CYCLES);
                        if (E_B == 32'd0) {shi_d, slo_d} = {hi_q, lo_q};
                        else              {shi_d, slo_d} = {rem, quo};
                    end else begin
                        cnt_d = 4'(MULT_CYCLES);
                        {shi_d, slo_d} = prod;
                    end
`ifdef MDU_MADD_EN
                    acc_d = {E_mdop == 4'd8, E_mdop == 4'd7};
`endif
                end else if (E_mdop == 4'd5) begin
                    hi_d = E_A;
                end else if (E_mdop == 4'd6) begin
                    lo_d = E_A;
                end
            end
            RUN: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
`ifdef MDU_MADD_EN
                    // Accumulate against HI/LO as they stand at completion.
                    unique case (acc_q)
                        2'b01:   {hi_d, lo_d} = {hi_q, lo_q} + {shi_q, slo_q};
                        2'b10:   {hi_d, lo_d} = {hi_q, lo_q} - {shi_q, slo_q};
                        default: {hi_d, lo_d} = {shi_q, slo_q};
                    endcase
`else
                    {hi_d, lo_d} = {shi_q, slo_q};
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            shi_q   <= 32'd0;
            slo_q   <= 32'd0;
`ifdef MDU_MADD_EN
            acc_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            shi_q   <= shi_d;
            slo_q   <= slo_d;
`ifdef MDU_MADD_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign busy     = (state_q == RUN);
    assign md_stall = D_md_use && (start || busy);
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, corner sequences, and
// randomized ops against an arithmetic reference model.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] E_A, E_B;
    logic [3:0]  E_mdop;
    logic        D_md_use;
    logic        start, busy, md_stall;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_A(E_A), .E_B(E_B),
        .E_mdop(E_mdop), .D_md_use(D_md_use), .start(start),
        .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // An op arriving while busy is a pipeline-use error.
    always @(negedge clk) begin
        if (!reset && busy && E_mdop != 4'd0) begin
            bad++;
            $display("FAIL op_while_busy: op %0d", E_mdop);
        end
    end

    function automatic logic [63:0] model(input int op, input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint q, r;
        longint unsigned uq, ur;
        case (op)
            1: return 64'(sa * sb);
            2: return ua * ub;
            3: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4: begin
                if (b == 32'd0) return {hi, lo};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            7: return {hi, lo} + 64'(sa * sb);
            8: return {hi, lo} - 64'(sa * sb);
            default: return {hi, lo};
        endcase
    endfunction

    // Issue one multi-cycle op from idle; measure busy length and stall.
    task automatic run_multi(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic use_d,
                             output int lat, output bit stall_ok,
                             output bit st);
        E_mdop = op;
        E_A = a;
        E_B = b;
        D_md_use = use_d;
        #1;
        st = start;
        stall_ok = (md_stall === use_d);
        tick;
        E_mdop = 4'd0;
        lat = 0;
        while (busy && lat < 40) begin
            lat++;
            #1;
            if (md_stall !== use_d) stall_ok = 0;
            tick;
        end
        #1;
        if (md_stall !== 1'b0) stall_ok = 0;
        D_md_use = 1'b0;
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a);
        E_mdop = op;
        E_A = a;
        tick;
        E_mdop = 4'd0;
    endtask

    int lat;
    bit sok, st;
    logic [31:0] hi_m, lo_m;
    logic [63:0] e;

    initial begin
        vecs[0] = '{4'd1, 32'd3, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFA, MC};
        vecs[1] = '{4'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DC};
        vecs[2] = '{4'd4, 32'd7, 32'd2, 64'h00000001_00000003, DC};
        vecs[3] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    64'hFFFFFFFE_00000001, MC};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF,
                    64'h00000000_80000000, DC};
        vecs[5] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    64'h00000000_00000001, MC};

        reset = 1'b1;
        E_A = 0;
        E_B = 0;
        E_mdop = 0;
        D_md_use = 0;
        tick;
        tick;
        chk("reset_state", {31'd0, busy, HI, LO}, 64'd0);
        reset = 1'b0;
        tick;

        foreach (vecs[i]) begin
            run_multi(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, lat, sok, st);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_start", i), {63'd0, st}, 64'd1);
            chk($sformatf("vec%0d_stall", i), {63'd0, sok}, 64'd1);
            chk($sformatf("vec%0d_hilo", i), {HI, LO}, vecs[i].exp);
        end

        move(4'd5, 32'h12345678);
        chk("mthi_nobusy", {63'd0, busy}, 64'd0);
        move(4'd6, 32'h9);
        chk("mtlo_nobusy", {63'd0, busy}, 64'd0);
        chk("mthi_mtlo", {HI, LO}, 64'h12345678_00000009);

        move(4'd5, 32'hA);
        move(4'd6, 32'hB);
        run_multi(4'd4, 32'd77, 32'd0, 1'b1, lat, sok, st);
        chk("divz_lat", 64'(lat), 64'(DC));
        chk("divz_hilo", {HI, LO}, 64'h0000000A_0000000B);

        run_multi(4'd2, 32'd6, 32'd7, 1'b0, lat, sok, st);
        chk("nouse_stall", {63'd0, sok}, 64'd1);
        chk("nouse_hilo", {HI, LO}, 64'd42);

`ifdef MDU_MADD_EN
        move(4'd5, 32'd0);
        move(4'd6, 32'd1);
        run_multi(4'd7, 32'd2, 32'd3, 1'b1, lat, sok, st);
        chk("madd_lat", 64'(lat), 64'(MC));
        chk("madd_hilo", {HI, LO}, 64'd7);
        run_multi(4'd8, 32'd4, 32'd5, 1'b1, lat, sok, st);
        chk("msub_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFF3);
`else
        E_mdop = 4'd7;
        E_A = 32'd2;
        E_B = 32'd3;
        #1;
        chk("op7_nostart", {63'd0, start}, 64'd0);
        tick;
        E_mdop = 4'd8;
        #1;
        chk("op8_nostart", {63'd0, start}, 64'd0);
        tick;
        E_mdop = 4'd0;
        chk("op78_none", {31'd0, busy, HI, LO}, 64'd42);
`endif

        move(4'd5, 32'h55);
        E_mdop = 4'd3;
        E_A = 32'd100;
        E_B = 32'd7;
        tick;
        E_mdop = 4'd0;
        tick;
        tick;
        chk("rst_midop_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_midop", {31'd0, busy, HI, LO}, 64'd0);
        repeat (15) tick;
        chk("rst_no_late", {31'd0, busy, HI, LO}, 64'd0);

        hi_m = 32'd0;
        lo_m = 32'd0;
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(1, 6));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (op <= 4'd4) begin
                e = model(int'(op), a, b, hi_m, lo_m);
                run_multi(op, a, b, 1'b1, lat, sok, st);
                chk($sformatf("rnd%0d_lat", n), 64'(lat),
                    64'((op <= 4'd2) ? MC : DC));
                chk($sformatf("rnd%0d_stall", n), {63'd0, sok}, 64'd1);
            end else begin
                e = (op == 4'd5) ? {a, lo_m} : {hi_m, a};
                move(op, a);
            end
            {hi_m, lo_m} = e;
            chk($sformatf("rnd%0d_op%0d_hilo", n, op), {HI, LO}, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
